// File: rtl/psram_pkg.sv
// Shared types and sizes for the PSRAM arbiter slice.
package psram_pkg;

    typedef enum logic [1:0] {
        INIT      = 2'd0,
        IDLE      = 2'd1,
        ISSUE     = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

    localparam int PSRAM_ADDR_W = 24;
    localparam int PSRAM_DATA_W = 16;

endpackage

// File: rtl/psram_arbiter_rr_pick.sv
// Round-robin picker: first set request bit at or after ptr, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    // Scan from the farthest candidate back to ptr so the nearest set bit overwrites the rest.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            int c;
            c = int'(ptr) + i;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (req[IDX_W'(c)]) begin
                valid = 1'b1;
                idx   = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/psram_arbiter.sv
// Round-robin arbiter sharing one QPI PSRAM controller port among NUM_REQ masters.
// The winner's command is latched at grant and held until completion or watchdog abort.
module psram_arbiter
    import psram_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = PSRAM_ADDR_W,
    parameter int DATA_W  = PSRAM_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_REQ-1:0]          i_req,
    input  logic [NUM_REQ-1:0]          i_req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   i_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   i_req_din,
    output logic [NUM_REQ-1:0]          o_ack,
    output logic [DATA_W-1:0]           o_rdata,
    output logic [NUM_REQ-1:0]          o_gnt,
    output logic                        o_ready,
    output logic                        o_timeout,
    output logic                        o_mem_stb,
    output logic                        o_mem_we,
    output logic [ADDR_W-1:0]           o_mem_addr,
    output logic [DATA_W-1:0]           o_mem_din,
    input  logic                        i_mem_busy,
    input  logic                        i_mem_done,
    input  logic [DATA_W-1:0]           i_mem_dout
);

    localparam int         IDX_W     = $clog2(NUM_REQ);
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    arb_state_t          state, nxt_state;
    logic [IDX_W-1:0]    rr_ptr, nxt_rr_ptr;
    logic [IDX_W-1:0]    owner, nxt_owner;
    logic [7:0]          wdog, nxt_wdog;
    logic                do_abort;

    logic [NUM_REQ-1:0]  nxt_ack, nxt_gnt;
    logic [DATA_W-1:0]   nxt_rdata, nxt_din;
    logic [ADDR_W-1:0]   nxt_addr;
    logic                nxt_ready, nxt_timeout, nxt_stb, nxt_we;

    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;

    // Pointer after the given owner, wrapping at NUM_REQ (NUM_REQ need not be a power of two).
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p);
        if (int'(p) == NUM_REQ - 1) return '0;
        return p + IDX_W'(1);
    endfunction

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (i_req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Next-state and next-output logic; every register holds unless a state says otherwise.
    always_comb begin
        nxt_state   = state;
        nxt_rr_ptr  = rr_ptr;
        nxt_owner   = owner;
        nxt_wdog    = wdog;
        nxt_ack     = '0;
        nxt_rdata   = o_rdata;
        nxt_gnt     = o_gnt;
        nxt_ready   = o_ready;
        nxt_timeout = o_timeout;
        nxt_stb     = o_mem_stb;
        nxt_we      = o_mem_we;
        nxt_addr    = o_mem_addr;
        nxt_din     = o_mem_din;
        do_abort    = 1'b0;

        case (state)
            INIT: begin
                // Controller must report idle-after-init before anyone is served.
                if (!i_mem_busy && i_mem_done) begin
                    nxt_ready = 1'b1;
                    nxt_state = IDLE;
                end
            end
            IDLE: begin
                if (pick_valid) begin
                    nxt_owner = pick_idx;
                    nxt_gnt   = NUM_REQ'(1) << pick_idx;
                    nxt_stb   = 1'b1;
                    nxt_we    = i_req_we[pick_idx];
                    nxt_addr  = i_req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    nxt_din   = i_req_din[int'(pick_idx)*DATA_W +: DATA_W];
                    nxt_wdog  = '0;
                    nxt_state = ISSUE;
                end
            end
            ISSUE: begin
                if (i_mem_busy) begin
                    nxt_stb   = 1'b0;
                    nxt_wdog  = '0;
                    nxt_state = WAIT_DONE;
                end else if (wdog == WDOG_LAST) begin
                    do_abort = 1'b1;
                end else begin
                    nxt_wdog = wdog + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (!i_mem_busy && i_mem_done) begin
                    nxt_rdata  = i_mem_dout;
                    nxt_ack    = o_gnt;
                    nxt_gnt    = '0;
                    nxt_rr_ptr = next_ptr(owner);
                    nxt_state  = IDLE;
                end else if (wdog == WDOG_LAST) begin
                    do_abort = 1'b1;
                end else begin
                    nxt_wdog = wdog + 8'd1;
                end
            end
            default: nxt_state = INIT;
        endcase

        // Watchdog abort: release the owner with zero data and force the controller to re-report ready.
        if (do_abort) begin
            nxt_timeout = 1'b1;
            nxt_stb     = 1'b0;
            nxt_ack     = o_gnt;
            nxt_rdata   = '0;
            nxt_gnt     = '0;
            nxt_rr_ptr  = next_ptr(owner);
            nxt_ready   = 1'b0;
            nxt_state   = INIT;
        end
    end

    // State, pointer, watchdog and all registered outputs; async reset clears everything.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= INIT;
            rr_ptr     <= '0;
            owner      <= '0;
            wdog       <= '0;
            o_ack      <= '0;
            o_rdata    <= '0;
            o_gnt      <= '0;
            o_ready    <= 1'b0;
            o_timeout  <= 1'b0;
            o_mem_stb  <= 1'b0;
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_din  <= '0;
        end else begin
            state      <= nxt_state;
            rr_ptr     <= nxt_rr_ptr;
            owner      <= nxt_owner;
            wdog       <= nxt_wdog;
            o_ack      <= nxt_ack;
            o_rdata    <= nxt_rdata;
            o_gnt      <= nxt_gnt;
            o_ready    <= nxt_ready;
            o_timeout  <= nxt_timeout;
            o_mem_stb  <= nxt_stb;
            o_mem_we   <= nxt_we;
            o_mem_addr <= nxt_addr;
            o_mem_din  <= nxt_din;
        end
    end

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter with a small behavioural PSRAM controller model.
module tb_psram_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 16;

    logic                       i_clk = 1'b0;
    logic                       i_rst = 1'b1;
    logic [NUM_REQ-1:0]         i_req = '0;
    logic [NUM_REQ-1:0]         i_req_we = '0;
    logic [NUM_REQ*ADDR_W-1:0]  i_req_addr = '0;
    logic [NUM_REQ*DATA_W-1:0]  i_req_din = '0;
    logic [NUM_REQ-1:0]         o_ack;
    logic [DATA_W-1:0]          o_rdata;
    logic [NUM_REQ-1:0]         o_gnt;
    logic                       o_ready;
    logic                       o_timeout;
    logic                       o_mem_stb;
    logic                       o_mem_we;
    logic [ADDR_W-1:0]          o_mem_addr;
    logic [DATA_W-1:0]          o_mem_din;
    logic                       i_mem_busy = 1'b0;
    logic                       i_mem_done = 1'b0;
    logic [DATA_W-1:0]          i_mem_dout = '0;

    // controller model knobs, written only by the stimulus block
    bit          mdl_en   = 1'b0;
    bit          mdl_hang = 1'b0;
    int          mdl_lat  = 3;
    logic [15:0] mdl_rd   = '0;
    // model-private state
    int          mdl_cnt       = 0;
    bit          stb_busy_viol = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    psram_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (255)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req      (i_req),
        .i_req_we   (i_req_we),
        .i_req_addr (i_req_addr),
        .i_req_din  (i_req_din),
        .o_ack      (o_ack),
        .o_rdata    (o_rdata),
        .o_gnt      (o_gnt),
        .o_ready    (o_ready),
        .o_timeout  (o_timeout),
        .o_mem_stb  (o_mem_stb),
        .o_mem_we   (o_mem_we),
        .o_mem_addr (o_mem_addr),
        .o_mem_din  (o_mem_din),
        .i_mem_busy (i_mem_busy),
        .i_mem_done (i_mem_done),
        .i_mem_dout (i_mem_dout)
    );

    always #5 i_clk = ~i_clk;

    // Controller model, updated on the falling edge: accepts a strobe, stays busy mdl_lat cycles, then reports done.
    always @(negedge i_clk) begin
        if (o_mem_stb && i_mem_busy) stb_busy_viol = 1'b1;
        if (!mdl_en) begin
            i_mem_busy = 1'b0;
            i_mem_done = 1'b0;
            mdl_cnt    = 0;
        end else if (i_mem_busy) begin
            if (!mdl_hang) begin
                if (mdl_cnt == 0) begin
                    i_mem_busy = 1'b0;
                    i_mem_done = 1'b1;
                    i_mem_dout = mdl_rd;
                end else begin
                    mdl_cnt = mdl_cnt - 1;
                end
            end
        end else if (o_mem_stb) begin
            i_mem_busy = 1'b1;
            i_mem_done = 1'b0;
            mdl_cnt    = mdl_lat;
        end else begin
            i_mem_done = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_ack(input int max, output int n);
        n = 0;
        while (n < max) begin
            tick();
            n++;
            if (o_ack != '0) return;
        end
    endtask

    task automatic set_req(input int k, input logic we, input logic [23:0] addr, input logic [15:0] din);
        i_req_we[k]               = we;
        i_req_addr[k*ADDR_W +: ADDR_W] = addr;
        i_req_din[k*DATA_W +: DATA_W]  = din;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},     32'(o_ack),      32'h0);
        chk({tag, "_rdata"},   32'(o_rdata),    32'h0);
        chk({tag, "_gnt"},     32'(o_gnt),      32'h0);
        chk({tag, "_ready"},   32'(o_ready),    32'h0);
        chk({tag, "_timeout"}, 32'(o_timeout),  32'h0);
        chk({tag, "_stb"},     32'(o_mem_stb),  32'h0);
        chk({tag, "_we"},      32'(o_mem_we),   32'h0);
        chk({tag, "_addr"},    32'(o_mem_addr), 32'h0);
        chk({tag, "_din"},     32'(o_mem_din),  32'h0);
    endtask

    initial begin
        int n;
        int ord [4];
        ord = '{0, 1, 2, 0};

        // ---- reset and INIT handshake ----
        repeat (3) tick();
        chk_all_zero("rst");
        #2 i_rst = 1'b0;
        i_req = 3'b001;
        set_req(0, 1'b0, 24'h000111, 16'h0);
        for (int c = 0; c < 50; c++) begin
            tick();
            chk("init_ready", 32'(o_ready), 32'h0);
            chk("init_gnt",   32'(o_gnt),   32'h0);
        end
        i_req  = 3'b000;
        mdl_en = 1'b1;
        tick();
        chk("ready_rise", 32'(o_ready), 32'h1);
        chk("ready_gnt",  32'(o_gnt),   32'h0);

        // ---- single read from requester 1 ----
        set_req(1, 1'b0, 24'h012345, 16'h0);
        mdl_rd  = 16'hBEEF;
        mdl_lat = 3;
        i_req   = 3'b010;
        tick();
        chk("rd_gnt",  32'(o_gnt),      32'h2);
        chk("rd_stb",  32'(o_mem_stb),  32'h1);
        chk("rd_addr", 32'(o_mem_addr), 32'h012345);
        chk("rd_we",   32'(o_mem_we),   32'h0);
        wait_ack(30, n);
        chk("rd_ack",   32'(o_ack),   32'h2);
        chk("rd_rdata", 32'(o_rdata), 32'hBEEF);
        chk("rd_gnt0",  32'(o_gnt),   32'h0);
        i_req = 3'b000;
        tick();
        chk("rd_ack_pulse", 32'(o_ack), 32'h0);

        // ---- write from requester 2 with inputs changing mid-transaction ----
        set_req(2, 1'b1, 24'h00FF00, 16'h1234);
        mdl_rd  = 16'h7777;
        mdl_lat = 5;
        i_req   = 3'b100;
        tick();
        chk("wr_gnt",  32'(o_gnt),      32'h4);
        chk("wr_we",   32'(o_mem_we),   32'h1);
        chk("wr_addr", 32'(o_mem_addr), 32'h00FF00);
        chk("wr_din",  32'(o_mem_din),  32'h1234);
        set_req(2, 1'b0, 24'hABCDEF, 16'h5555);
        n = 0;
        while (o_ack == '0 && n < 30) begin
            tick();
            n++;
            chk("wr_hold_addr", 32'(o_mem_addr), 32'h00FF00);
            chk("wr_hold_din",  32'(o_mem_din),  32'h1234);
            chk("wr_hold_we",   32'(o_mem_we),   32'h1);
        end
        chk("wr_ack",   32'(o_ack),   32'h4);
        chk("wr_rdata", 32'(o_rdata), 32'h7777);
        i_req = 3'b000;
        tick();

        // ---- three simultaneous held requests: order 0,1,2,0 ----
        for (int k = 0; k < NUM_REQ; k++) set_req(k, 1'b0, 24'h0A0000 | 24'(k), 16'h0);
        mdl_lat = 2;
        i_req   = 3'b111;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("rr_gnt",  32'(o_gnt),      32'(1) << ord[i]);
            chk("rr_addr", 32'(o_mem_addr), 32'h0A0000 | 32'(ord[i]));
            mdl_rd = 16'hA000 + 16'(i);
            wait_ack(30, n);
            chk("rr_ack",   32'(o_ack),   32'(1) << ord[i]);
            chk("rr_rdata", 32'(o_rdata), 32'hA000 + 32'(i));
            chk("rr_gap",   32'(o_gnt),   32'h0);
            if (i == 3) i_req = 3'b000;
            tick();
        end
        chk("rr_idle_gnt",  32'(o_gnt),       32'h0);
        chk("stb_vs_busy",  32'(stb_busy_viol), 32'h0);

        // ---- controller hangs busy: watchdog abort ----
        mdl_hang = 1'b1;
        mdl_lat  = 3;
        set_req(0, 1'b0, 24'h000ABC, 16'h0);
        i_req = 3'b001;
        tick();
        chk("to_gnt", 32'(o_gnt), 32'h1);
        n = 0;
        while (o_mem_stb && n < 10) begin
            tick();
            n++;
        end
        chk("to_stb_low", 32'(o_mem_stb), 32'h0);
        wait_ack(300, n);
        chk("to_cycles",  32'(n),         32'd255);
        chk("to_ack",     32'(o_ack),     32'h1);
        chk("to_rdata",   32'(o_rdata),   32'h0);
        chk("to_flag",    32'(o_timeout), 32'h1);
        chk("to_ready",   32'(o_ready),   32'h0);
        chk("to_gnt0",    32'(o_gnt),     32'h0);
        i_req    = 3'b000;
        mdl_hang = 1'b0;
        n = 0;
        while (!o_ready && n < 20) begin
            tick();
            n++;
        end
        chk("to_reready", 32'(o_ready),   32'h1);
        chk("to_sticky",  32'(o_timeout), 32'h1);

        // ---- reset during WAIT_DONE ----
        mdl_lat = 20;
        set_req(1, 1'b0, 24'h000555, 16'h0);
        i_req = 3'b010;
        tick();
        chk("mr_gnt", 32'(o_gnt), 32'h2);
        tick();
        chk("mr_wait_stb", 32'(o_mem_stb), 32'h0);
        tick();
        tick();
        #3 i_rst = 1'b1;
        mdl_en = 1'b0;
        #1 chk_all_zero("mr_async");
        i_req = 3'b000;
        tick();
        tick();
        #2 i_rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("mr_no_ack",  32'(o_ack),   32'h0);
            chk("mr_init",    32'(o_ready), 32'h0);
        end
        mdl_en = 1'b1;
        tick();
        chk("mr_reready", 32'(o_ready), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
